crt_timing_gen: RTL and testbench
=================================

// Module: crt_timing_gen
// PURPOSE
//  Parametrised successor to the fixed-porch CRT controller. It derives a pixel-clock enable from
//  SystemClockFreq/CRTClockFreq using a fractional accumulator (exact average rate, no divider).
//  It generates hsync/vsync/xpos/ypos with runtime front-porch/sync/back-porch widths and
//  per-axis sync polarity, plus display_en, line/frame strobes and config-error detection.
//  It feeds the pong renderer and the VGA pins.
// PARAMETERS
//  RES_W     10  width of Xresolution/Yresolution/xpos/ypos
//  CLK_W     10  width of SystemClockFreq/CRTClockFreq
//  PORCH_W   8   width of each porch/sync width input
//  HSYNC_POL 0   active level of hsync
//  VSYNC_POL 0   active level of vsync
// PORTS
//  clock           in  1        system clock; all logic on posedge
//  reset           in  1        synchronous, active-low reset
//  SystemClockFreq in  CLK_W    system clock freq, any unit
//  CRTClockFreq    in  CLK_W    pixel freq, same unit
//  Xresolution     in  RES_W    active pixels per line
//  Yresolution     in  RES_W    active lines per frame
//  h_fp,h_sync,h_bp in PORCH_W  horizontal front porch / sync / back porch, in pixels
//  v_fp,v_sync,v_bp in PORCH_W  vertical porches / sync, in lines
//  enable          in  1        run request; sampled at frame boundaries
//  hsync,vsync     out 1        sync outputs at the parameter polarity
//  xpos,ypos       out RES_W    active-area coordinate; 0 outside the active area
//  display_en      out 1        1 when (x,y) is inside the active area
//  pixel_tick      out 1        1-cycle pulse when the position updates
//  line_start      out 1        1-cycle pulse, coincident with the tick when hcount becomes 0
//  frame_start     out 1        1-cycle pulse, coincident with the tick when (h,v) becomes (0,0)
//  cfg_error       out 1        sticky until the next config load or reset
// BEHAVIOUR
//  Reset (reset==0 at posedge): FSM=IDLE, acc=0, hcount=vcount=0.
//   Outputs after reset: hsync=~HSYNC_POL, vsync=~VSYNC_POL, xpos=ypos=0.
//   display_en, pixel_tick, line_start, frame_start and cfg_error are all 0.
//   Reset applies mid-frame immediately; no partial frame completes.
//  Tick: each cycle acc+=CRTClockFreq. If acc>=SystemClockFreq then acc-=SystemClockFreq and tick=1.
//   The accumulator is CLK_W+1 bits wide. CRTClockFreq==SystemClockFreq gives a tick every cycle.
//  Horizontal: Htotal=Xres+h_fp+h_sync+h_bp. Vertical: Vtotal=Yres+v_fp+v_sync+v_bp.
//   Both counts are computed at RES_W+2 bits (no overflow).
//  Horizontal regions: active [0,Xres); FP [Xres,Xres+fp); sync [..,..+sync); BP up to Htotal-1.
//   The vertical axis uses the same regions, in lines.
//  FSM IDLE -> RUN: taken on a tick when enable==1 and the config is valid.
//   On that tick: latch all config inputs into shadow registers and set h=v=0.
//   Assert frame_start, line_start and display_en.
//  FSM RUN: on each tick h++. At h==Htotal-1 the next value is h=0 and v++ (with line_start).
//   At v==Vtotal-1 the next value is v=0 (frame boundary).
//  At the frame boundary: if enable==1 and the live config is valid, relatch it and continue
//   (frame_start pulses). Otherwise go to IDLE with idle outputs.
//   A config change mid-frame has no effect until the next boundary.
//  Outputs are registered and decoded from the next-state counters.
//   Position, syncs and strobes change on the same edge as pixel_tick; zero added latency.
//  Invalid config: Xres==0, Yres==0, h_sync==0, v_sync==0, CRTClockFreq==0,
//   or CRTClockFreq>SystemClockFreq. Any of these sets cfg_error=1 and keeps/returns FSM in IDLE.
//   In this case no ticks are emitted.
//  Zero-width porches (fp/bp==0) are legal.
//  Between ticks, all outputs hold their values; strobes stay 0.
// STRUCTURE
//  Include crt_timing_defs.vh: FSM encodings (IDLE/RUN) and region localparams.
//  Sub-module crt_pixel_tick_gen: fractional accumulator plus freq-error flag.
//  The top level holds the FSM, counters, shadow config and output decode.
// TESTING
//  Sys=10, CRT=2, X=10, Y=4, h=2/3/1, v=1/2/1, enable=1, reset low 3 cycles
//   -> pixel_tick every 5 cycles; Htotal=16, Vtotal=8; frame = 128 ticks = 640 cycles.
//  Same config -> hsync==HSYNC_POL exactly for h=12..14 each line; vsync active for v=5..6.
//   display_en is high for 40 ticks per frame.
//  Sys=10, CRT=3 -> exactly 3 ticks in every 10-cycle window. Sys=CRT=7 -> a tick every cycle.
//  Change Xres 10->8 mid-frame -> current frame keeps Htotal=16; next frame Htotal=14.
//   frame_start pulses once per frame.
//  CRT=12 > Sys=10, or h_sync=0 -> cfg_error=1, FSM stays IDLE, no ticks, syncs inactive.
//   Fixing the config clears cfg_error at the next tick-eligible load.
//  reset low mid-line -> next cycle all outputs equal reset values.
//   After reset returns high, frame_start pulses on the first tick with xpos=ypos=0.

Source files
------------

// File: rtl/crt_timing_gen_pkg.sv
// Shared types and helpers for the CRT timing generator: FSM states, blanking
// regions and the configuration validity rules.
package crt_timing_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        RG_ACTIVE = 2'd0,
        RG_FP     = 2'd1,
        RG_SYNC   = 2'd2,
        RG_BP     = 2'd3
    } region_e;

    // Region of a position along one axis; everything past the sync pulse is back porch.
    function automatic region_e region_of(input logic [31:0] pos, input logic [31:0] size,
                                          input logic [31:0] fp, input logic [31:0] sync);
        if (pos < size)
            return RG_ACTIVE;
        if (pos < size + fp)
            return RG_FP;
        if (pos < size + fp + sync)
            return RG_SYNC;
        return RG_BP;
    endfunction

    function automatic logic freq_ok(input logic [31:0] sys, input logic [31:0] crt);
        return (crt != 32'd0) && (crt <= sys);
    endfunction

    function automatic logic geom_ok(input logic [31:0] xres, input logic [31:0] yres,
                                     input logic [31:0] hsync, input logic [31:0] vsync);
        return (xres != 32'd0) && (yres != 32'd0) && (hsync != 32'd0) && (vsync != 32'd0);
    endfunction

endpackage

// File: rtl/crt_timing_gen_tick.sv
// Fractional pixel-clock enable: adds the pixel frequency every cycle and emits a
// tick each time the sum crosses the system frequency.
module crt_pixel_tick_gen
    import crt_timing_gen_pkg::*;
#(
    parameter int CLK_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [CLK_W-1:0] sys_freq_i,
    input  logic [CLK_W-1:0] crt_freq_i,
    output logic             tick_o,
    output logic             freq_err_o
);

    logic [CLK_W:0] acc_q, acc_d, sum;

    always_comb begin
        freq_err_o = !freq_ok(32'(sys_freq_i), 32'(crt_freq_i));
        sum        = acc_q + {1'b0, crt_freq_i};
        tick_o     = !freq_err_o && (sum >= {1'b0, sys_freq_i});
        acc_d      = sum;
        // A bad ratio parks the accumulator so a fixed config starts from a clean phase.
        if (freq_err_o)
            acc_d = '0;
        else if (tick_o)
            acc_d = sum - {1'b0, sys_freq_i};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

endmodule

// File: rtl/crt_timing_gen.sv
// CRT/VGA timing generator with runtime porches, per-axis sync polarity and a
// frame-boundary shadowed configuration.
module crt_timing_gen
    import crt_timing_gen_pkg::*;
#(
    parameter int RES_W     = 10,
    parameter int CLK_W     = 10,
    parameter int PORCH_W   = 8,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [CLK_W-1:0]   SystemClockFreq,
    input  logic [CLK_W-1:0]   CRTClockFreq,
    input  logic [RES_W-1:0]   Xresolution,
    input  logic [RES_W-1:0]   Yresolution,
    input  logic [PORCH_W-1:0] h_fp,
    input  logic [PORCH_W-1:0] h_sync,
    input  logic [PORCH_W-1:0] h_bp,
    input  logic [PORCH_W-1:0] v_fp,
    input  logic [PORCH_W-1:0] v_sync,
    input  logic [PORCH_W-1:0] v_bp,
    input  logic               enable,
    output logic               hsync,
    output logic               vsync,
    output logic [RES_W-1:0]   xpos,
    output logic [RES_W-1:0]   ypos,
    output logic               display_en,
    output logic               pixel_tick,
    output logic               line_start,
    output logic               frame_start,
    output logic               cfg_error
);

    localparam int CW = RES_W + 2;

    typedef struct packed {
        logic [CLK_W-1:0]   sys;
        logic [CLK_W-1:0]   crt;
        logic [RES_W-1:0]   xres;
        logic [RES_W-1:0]   yres;
        logic [PORCH_W-1:0] h_fp;
        logic [PORCH_W-1:0] h_sync;
        logic [PORCH_W-1:0] h_bp;
        logic [PORCH_W-1:0] v_fp;
        logic [PORCH_W-1:0] v_sync;
        logic [PORCH_W-1:0] v_bp;
    } cfg_t;

    cfg_t             live_cfg, cfg_q, cfg_d;
    state_e           state_q, state_d;
    logic [CW-1:0]    h_q, h_d, v_q, v_d, htot, vtot;
    logic             cfg_err_q, cfg_err_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic             ptick_q, ptick_d, lstart_q, lstart_d, fstart_q, fstart_d;
    logic [RES_W-1:0] xpos_q, xpos_d, ypos_q, ypos_d;
    logic [CLK_W-1:0] sel_sys, sel_crt;
    logic             tick, freq_err, live_ok, load, line_evt, frame_evt, run_d, de_n;
    region_e          hreg, vreg;

    always_comb begin
        live_cfg.sys    = SystemClockFreq;
        live_cfg.crt    = CRTClockFreq;
        live_cfg.xres   = Xresolution;
        live_cfg.yres   = Yresolution;
        live_cfg.h_fp   = h_fp;
        live_cfg.h_sync = h_sync;
        live_cfg.h_bp   = h_bp;
        live_cfg.v_fp   = v_fp;
        live_cfg.v_sync = v_sync;
        live_cfg.v_bp   = v_bp;
    end

    // The pixel rate follows the frame's shadow copy while running, the live inputs while idle.
    assign sel_sys = (state_q == ST_RUN) ? cfg_q.sys : SystemClockFreq;
    assign sel_crt = (state_q == ST_RUN) ? cfg_q.crt : CRTClockFreq;

    crt_pixel_tick_gen #(.CLK_W(CLK_W)) u_tick (
        .clk_i      (clock),
        .rst_ni     (reset),
        .sys_freq_i (sel_sys),
        .crt_freq_i (sel_crt),
        .tick_o     (tick),
        .freq_err_o (freq_err)
    );

    assign live_ok = geom_ok(32'(Xresolution), 32'(Yresolution), 32'(h_sync), 32'(v_sync))
                  && ((state_q == ST_RUN) ? freq_ok(32'(SystemClockFreq), 32'(CRTClockFreq))
                                          : !freq_err);

    assign htot = CW'(cfg_q.xres) + CW'(cfg_q.h_fp) + CW'(cfg_q.h_sync) + CW'(cfg_q.h_bp);
    assign vtot = CW'(cfg_q.yres) + CW'(cfg_q.v_fp) + CW'(cfg_q.v_sync) + CW'(cfg_q.v_bp);

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        h_d       = h_q;
        v_d       = v_q;
        cfg_err_d = cfg_err_q;
        load      = 1'b0;
        line_evt  = 1'b0;
        frame_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && !live_ok)
                    cfg_err_d = 1'b1;
                else if (enable && tick)
                    load = 1'b1;
            end
            ST_RUN: begin
                if (tick) begin
                    if (h_q == htot - CW'(1)) begin
                        h_d      = '0;
                        line_evt = 1'b1;
                        if (v_q == vtot - CW'(1)) begin
                            if (enable && live_ok) begin
                                load = 1'b1;
                            end else begin
                                state_d  = ST_IDLE;
                                v_d      = '0;
                                line_evt = 1'b0;
                                if (enable)
                                    cfg_err_d = 1'b1;
                            end
                        end else begin
                            v_d = v_q + CW'(1);
                        end
                    end else begin
                        h_d = h_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            state_d   = ST_RUN;
            cfg_d     = live_cfg;
            h_d       = '0;
            v_d       = '0;
            cfg_err_d = 1'b0;
            line_evt  = 1'b1;
            frame_evt = 1'b1;
        end
    end

    // Outputs decode the next-state position so they land on the same edge as the tick.
    always_comb begin
        hreg     = region_of(32'(h_d), 32'(cfg_d.xres), 32'(cfg_d.h_fp), 32'(cfg_d.h_sync));
        vreg     = region_of(32'(v_d), 32'(cfg_d.yres), 32'(cfg_d.v_fp), 32'(cfg_d.v_sync));
        run_d    = (state_d == ST_RUN);
        de_n     = run_d && (hreg == RG_ACTIVE) && (vreg == RG_ACTIVE);
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        de_d     = de_q;
        xpos_d   = xpos_q;
        ypos_d   = ypos_q;
        ptick_d  = 1'b0;
        lstart_d = 1'b0;
        fstart_d = 1'b0;
        if (tick) begin
            ptick_d  = run_d;
            lstart_d = line_evt;
            fstart_d = frame_evt;
            hsync_d  = (run_d && hreg == RG_SYNC) ? HSYNC_POL : !HSYNC_POL;
            vsync_d  = (run_d && vreg == RG_SYNC) ? VSYNC_POL : !VSYNC_POL;
            de_d     = de_n;
            xpos_d   = de_n ? h_d[RES_W-1:0] : '0;
            ypos_d   = de_n ? v_d[RES_W-1:0] : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cfg_q     <= '0;
            h_q       <= '0;
            v_q       <= '0;
            cfg_err_q <= 1'b0;
            hsync_q   <= !HSYNC_POL;
            vsync_q   <= !VSYNC_POL;
            de_q      <= 1'b0;
            xpos_q    <= '0;
            ypos_q    <= '0;
            ptick_q   <= 1'b0;
            lstart_q  <= 1'b0;
            fstart_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            h_q       <= h_d;
            v_q       <= v_d;
            cfg_err_q <= cfg_err_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            de_q      <= de_d;
            xpos_q    <= xpos_d;
            ypos_q    <= ypos_d;
            ptick_q   <= ptick_d;
            lstart_q  <= lstart_d;
            fstart_q  <= fstart_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_en  = de_q;
    assign xpos        = xpos_q;
    assign ypos        = ypos_q;
    assign pixel_tick  = ptick_q;
    assign line_start  = lstart_q;
    assign frame_start = fstart_q;
    assign cfg_error   = cfg_err_q;

endmodule

// File: tb/tb_crt_timing_gen.sv
// Directed bench for crt_timing_gen: reset state, tick rates, raster pattern against
// a small position model, mid-frame reconfiguration, config errors and mid-line reset.
module tb_crt_timing_gen;

    localparam int RES_W   = 10;
    localparam int CLK_W   = 10;
    localparam int PORCH_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, enable;
    logic [CLK_W-1:0]   sys_f, crt_f;
    logic [RES_W-1:0]   xres, yres;
    logic [PORCH_W-1:0] hfp_i, hsync_i, hbp_i, vfp_i, vsync_i, vbp_i;
    logic               hsync, vsync, display_en, pixel_tick, line_start, frame_start, cfg_error;
    logic [RES_W-1:0]   xpos, ypos;

    crt_timing_gen #(.RES_W(RES_W), .CLK_W(CLK_W), .PORCH_W(PORCH_W),
                     .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) dut (
        .clock(clk), .reset(rst_n), .SystemClockFreq(sys_f), .CRTClockFreq(crt_f),
        .Xresolution(xres), .Yresolution(yres),
        .h_fp(hfp_i), .h_sync(hsync_i), .h_bp(hbp_i),
        .v_fp(vfp_i), .v_sync(vsync_i), .v_bp(vbp_i),
        .enable(enable), .hsync(hsync), .vsync(vsync), .xpos(xpos), .ypos(ypos),
        .display_en(display_en), .pixel_tick(pixel_tick), .line_start(line_start),
        .frame_start(frame_start), .cfg_error(cfg_error)
    );

    int checks = 0, errors = 0;
    int mx, my, hfp, hsw, hbp, vfp, vsw, vbp, px, mh, mv, m_gap;
    int cyc = 0, last_tick, last_fs, fs_gap, n_tick, n_fs, n_ls, n_de, n_bad;
    int lat, cnt, badw, tot;
    logic [22:0] prev;
    logic [26:0] idle_outs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [26:0] outs();
        return {hsync, vsync, display_en, pixel_tick, line_start, frame_start, cfg_error, xpos, ypos};
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_cfg(input int s, input int c, input int x, input int y,
                           input int a, input int b, input int d,
                           input int e, input int f, input int g);
        sys_f = CLK_W'(s); crt_f = CLK_W'(c); xres = RES_W'(x); yres = RES_W'(y);
        hfp_i = PORCH_W'(a); hsync_i = PORCH_W'(b); hbp_i = PORCH_W'(d);
        vfp_i = PORCH_W'(e); vsync_i = PORCH_W'(f); vbp_i = PORCH_W'(g);
        mx = x; my = y; hfp = a; hsw = b; hbp = d; vfp = e; vsw = f; vbp = g; px = x;
    endtask

    task automatic wait_tick(input int bound, output int l);
        l = bound + 1;
        for (int i = 1; i <= bound; i++) begin
            step();
            if (pixel_tick) begin
                l = i;
                break;
            end
        end
    endtask

    task automatic clr_stats();
        n_tick = 0; n_fs = 0; n_ls = 0; n_de = 0; n_bad = 0;
    endtask

    // Called on the cycle the frame-start tick is seen: position (0,0).
    task automatic start_model();
        mh = 0; mv = 0; last_tick = cyc; last_fs = cyc; fs_gap = 0;
        prev = {hsync, vsync, display_en, xpos, ypos};
    endtask

    task automatic observe(input int n);
        for (int i = 0; i < n; i++) begin
            logic de_e, hs_e, vs_e;
            step();
            if (pixel_tick) begin
                n_tick++;
                mh++;
                if (mh == mx + hfp + hsw + hbp) begin
                    mh = 0;
                    mv++;
                    if (mv == my + vfp + vsw + vbp) begin
                        mv = 0;
                        mx = px;
                    end
                end
                de_e = (mh < mx) && (mv < my);
                hs_e = !((mh >= mx + hfp) && (mh < mx + hfp + hsw));
                vs_e = !((mv >= my + vfp) && (mv < my + vfp + vsw));
                if (display_en !== de_e || hsync !== hs_e || vsync !== vs_e) n_bad++;
                if (int'(xpos) != (de_e ? mh : 0) || int'(ypos) != (de_e ? mv : 0)) n_bad++;
                if (line_start !== (mh == 0) || frame_start !== (mh == 0 && mv == 0)) n_bad++;
                if (cyc - last_tick != m_gap) n_bad++;
                last_tick = cyc;
                if (frame_start) begin
                    n_fs++;
                    fs_gap  = cyc - last_fs;
                    last_fs = cyc;
                end
                if (line_start) n_ls++;
                if (display_en) n_de++;
            end else begin
                if (line_start || frame_start) n_bad++;
                if ({hsync, vsync, display_en, xpos, ypos} !== prev) n_bad++;
            end
            prev = {hsync, vsync, display_en, xpos, ypos};
        end
    endtask

    initial begin
        idle_outs = {2'b11, 25'd0};
        m_gap = 5;
        enable = 1'b1;
        rst_n = 1'b0;
        set_cfg(10, 2, 10, 4, 2, 3, 1, 1, 2, 1);
        repeat (3) step();
        chk("reset_outputs", 32'(outs()), 32'(idle_outs));

        rst_n = 1'b1;
        wait_tick(20, lat);
        chk("first_tick_latency", lat, 5);
        chk("first_strobes_de", {frame_start, line_start, display_en}, 3'b111);
        chk("first_xy", {xpos, ypos}, 0);

        start_model();
        clr_stats();
        observe(1280);
        chk("ticks_two_frames", n_tick, 256);
        chk("frame_starts", n_fs, 2);
        chk("line_starts", n_ls, 16);
        chk("display_ticks", n_de, 80);
        chk("frame_period", fs_gap, 640);
        chk("raster_pattern", n_bad, 0);

        clr_stats();
        observe(100);
        xres = RES_W'(8);
        px = 8;
        observe(1200);
        chk("xres_change_pattern", n_bad, 0);
        chk("xres_change_fs", n_fs, 2);
        chk("xres_new_period", fs_gap, 560);

        set_cfg(10, 3, 10, 4, 2, 3, 1, 1, 2, 1);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        badw = 0; tot = 0;
        for (int w = 0; w < 10; w++) begin
            cnt = 0;
            for (int i = 0; i < 10; i++) begin
                step();
                if (pixel_tick) cnt++;
            end
            if (cnt != 3) badw++;
            tot += cnt;
        end
        chk("ratio_3_10_windows", badw, 0);
        chk("ratio_3_10_total", tot, 30);

        set_cfg(7, 7, 10, 4, 2, 3, 1, 1, 2, 1);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        tot = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (pixel_tick) tot++;
        end
        chk("equal_freq_every_cycle", tot, 50);

        set_cfg(10, 12, 10, 4, 2, 3, 1, 1, 2, 1);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        tot = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (pixel_tick) tot++;
        end
        chk("crt_gt_sys_no_ticks", tot, 0);
        chk("crt_gt_sys_error", cfg_error, 1);
        chk("crt_gt_sys_idle", {hsync, vsync, display_en}, 3'b110);
        crt_f = CLK_W'(2);
        repeat (2) step();
        chk("error_sticky", cfg_error, 1);
        wait_tick(20, lat);
        chk("fix_latency", lat, 3);
        chk("fix_load", {frame_start, cfg_error}, 2'b10);

        hsync_i = '0;
        lat = 701;
        for (int i = 1; i <= 700; i++) begin
            step();
            if (cfg_error) begin
                lat = i;
                break;
            end
        end
        chk("hsync0_at_boundary", lat, 640);
        tot = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (pixel_tick) tot++;
        end
        chk("hsync0_no_ticks", tot, 0);
        chk("hsync0_idle_outputs", 32'(outs()), 32'({2'b11, 4'b0000, 1'b1, 20'd0}));

        hsync_i = PORCH_W'(3);
        wait_tick(20, lat);
        chk("restart_load", {frame_start, cfg_error}, 2'b10);
        repeat (37) step();
        rst_n = 1'b0;
        step();
        chk("midline_reset_outputs", 32'(outs()), 32'(idle_outs));
        rst_n = 1'b1;
        wait_tick(20, lat);
        chk("post_reset_latency", lat, 5);
        chk("post_reset_strobes", {frame_start, line_start, display_en}, 3'b111);
        chk("post_reset_xy", {xpos, ypos}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
